// File: rtl/alu_pkg.sv
// Shared opcode definitions for the arithmetic/logic unit and its shifter.
package alu_pkg;

  typedef logic [3:0] opcode_t;

  typedef enum logic [3:0] {
    OP_OR  = 4'd0,
    OP_XOR = 4'd1,
    OP_AND = 4'd2,
    OP_ROL = 4'd3,
    OP_SRL = 4'd4,
    OP_SLL = 4'd5,
    OP_ADD = 4'd8,
    OP_SUB = 4'd9,
    OP_SRA = 4'd10
  } alu_op_e;

endpackage

// File: rtl/alu_shifter.sv
// Combinational rotate/shift unit: ROL, SRL, SLL and SRA on operand a by amount b.
module alu_shifter
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  opcode_t          op,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH-1:0]   amt;
  logic [2*WIDTH-1:0] dbl;

  // Rotate via a doubled copy: the upper half after the left shift is the rotated value.
  assign amt = WIDTH'(b % WIDTH);
  assign dbl = {a, a} << amt;

  always_comb begin
    result = '0;
    case (op)
      OP_ROL:  result = dbl[2*WIDTH-1:WIDTH];
      OP_SRL:  result = a >> b;
      OP_SLL:  result = a << b;
      OP_SRA:  result = $signed(a) >>> b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/arithmetic_logic_unit.sv
// Single-cycle ALU: combinational logic/arithmetic/shift ops with one registered result stage.
module arithmetic_logic_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       select,
  output logic [WIDTH-1:0] out,
  output logic             negative,
  output logic             zero,
  output logic             carry_out,
  output logic             overflow
);

  logic [WIDTH-1:0] shift_res;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] res;
  logic             res_c;
  logic             res_v;

  alu_shifter #(.WIDTH(WIDTH)) u_shifter (
    .a      (a),
    .b      (b),
    .op     (select),
    .result (shift_res)
  );

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    res   = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    case (select)
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_AND: res = a & b;
      OP_ROL, OP_SRL, OP_SLL, OP_SRA: res = shift_res;
      OP_ADD: begin
        res   = sum[WIDTH-1:0];
        res_c = sum[WIDTH];
        res_v = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        // Borrow shows up in the extended bit; carry is its inverse.
        res   = diff[WIDTH-1:0];
        res_c = ~diff[WIDTH];
        res_v = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      default: res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= '0;
      negative  <= 1'b0;
      zero      <= 1'b1;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      out       <= res;
      negative  <= res[WIDTH-1];
      zero      <= (res == '0);
      carry_out <= res_c;
      overflow  <= res_v;
    end
  end

endmodule

// File: tb/tb_arithmetic_logic_unit.sv
// Self-checking bench: integer-arithmetic reference model checked every cycle plus literal vectors.
module tb_arithmetic_logic_unit;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   select;
  logic [W-1:0] out;
  logic         negative;
  logic         zero;
  logic         carry_out;
  logic         overflow;

  int checks = 0;
  int failures = 0;

  arithmetic_logic_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .select    (select),
    .out       (out),
    .negative  (negative),
    .zero      (zero),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Returns {out, negative, zero, carry, overflow} using plain integer arithmetic.
  function automatic logic [11:0] model(input logic r, input logic [7:0] ia, input logic [7:0] ib,
                                        input logic [3:0] s);
    int ua, ub, sa, sb, res, k, q;
    bit c, v;
    ua = int'(ia);
    ub = int'(ib);
    sa = (ua >= 128) ? ua - 256 : ua;
    sb = (ub >= 128) ? ub - 256 : ub;
    res = 0;
    c = 1'b0;
    v = 1'b0;
    if (r) return {8'h00, 4'b0100};
    case (s)
      4'd0: res = ua | ub;
      4'd1: res = ua ^ ub;
      4'd2: res = ua & ub;
      4'd3: begin
        res = ua;
        for (int i = 0; i < ub % W; i++) res = ((res * 2) % 256) + res / 128;
      end
      4'd4: res = (ub >= W) ? 0 : ua / (1 << ub);
      4'd5: res = (ub >= W) ? 0 : (ua * (1 << ub)) % 256;
      4'd8: begin
        res = ua + ub;
        c = (res >= 256);
        res = res % 256;
        v = (sa + sb > 127) || (sa + sb < -128);
      end
      4'd9: begin
        res = (ua - ub + 256) % 256;
        c = (ua >= ub);
        v = (sa - sb > 127) || (sa - sb < -128);
      end
      4'd10: begin
        k = (ub > W - 1) ? W - 1 : ub;
        q = (sa >= 0) ? sa / (1 << k) : -((-sa + (1 << k) - 1) / (1 << k));
        res = (q + 256) % 256;
      end
      default: res = 0;
    endcase
    return {res[7:0], res[7], (res == 0), c, v};
  endfunction

  // Every-cycle compare against the model, using inputs present at the edge.
  initial begin
    logic [11:0] exp_v;
    forever begin
      @(posedge clk);
      exp_v = model(rst, a, b, select);
      #1;
      checks++;
      if ({out, negative, zero, carry_out, overflow} !== exp_v) begin
        failures++;
        $display("FAIL model t=%0t actual=%h required=%h", $time,
                 {out, negative, zero, carry_out, overflow}, exp_v);
      end
    end
  end

  typedef struct {
    logic         r;
    logic [7:0]   va;
    logic [7:0]   vb;
    logic [3:0]   s;
    logic [7:0]   eo;
    logic [3:0]   nzcv;
  } vec_t;

  vec_t vecs[$] = '{
    '{1'b0, 8'h4B, 8'h04, 4'd0,  8'h4F, 4'b0000},
    '{1'b0, 8'h4B, 8'h04, 4'd1,  8'h4F, 4'b0000},
    '{1'b0, 8'h4B, 8'h04, 4'd2,  8'h00, 4'b0100},
    '{1'b0, 8'h4B, 8'h04, 4'd3,  8'hB4, 4'b1000},
    '{1'b0, 8'h4B, 8'h04, 4'd4,  8'h04, 4'b0000},
    '{1'b0, 8'h4B, 8'h04, 4'd5,  8'hB0, 4'b1000},
    '{1'b0, 8'h4B, 8'h04, 4'd10, 8'h04, 4'b0000},
    '{1'b0, 8'h4B, 8'h04, 4'd8,  8'h4F, 4'b0000},
    '{1'b0, 8'h4B, 8'h04, 4'd9,  8'h47, 4'b0010},
    '{1'b0, 8'h7F, 8'h01, 4'd8,  8'h80, 4'b1001},
    '{1'b0, 8'hFF, 8'h01, 4'd8,  8'h00, 4'b0110},
    '{1'b0, 8'h80, 8'h09, 4'd10, 8'hFF, 4'b1000},
    '{1'b0, 8'h80, 8'h09, 4'd4,  8'h00, 4'b0100},
    '{1'b0, 8'h00, 8'h01, 4'd9,  8'hFF, 4'b1000},
    '{1'b0, 8'h4B, 8'h04, 4'd6,  8'h00, 4'b0100},
    '{1'b0, 8'h4B, 8'h04, 4'd7,  8'h00, 4'b0100},
    '{1'b0, 8'h4B, 8'h04, 4'd11, 8'h00, 4'b0100},
    '{1'b0, 8'h4B, 8'h04, 4'd15, 8'h00, 4'b0100},
    '{1'b0, 8'h4B, 8'h09, 4'd3,  8'h96, 4'b1000},
    '{1'b0, 8'h4B, 8'h09, 4'd5,  8'h00, 4'b0100},
    '{1'b0, 8'hB4, 8'h02, 4'd10, 8'hED, 4'b1000},
    '{1'b0, 8'h80, 8'h80, 4'd9,  8'h00, 4'b0110},
    '{1'b0, 8'h80, 8'h01, 4'd9,  8'h7F, 4'b0011},
    '{1'b0, 8'hFF, 8'hFF, 4'd8,  8'hFE, 4'b1010},
    '{1'b1, 8'h7F, 8'h01, 4'd8,  8'h00, 4'b0100},
    '{1'b0, 8'h4B, 8'h04, 4'd0,  8'h4F, 4'b0000}
  };

  initial begin
    rst = 1'b1;
    a = 8'hAA;
    b = 8'h55;
    select = 4'd8;
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if ({out, negative, zero, carry_out, overflow} !== 12'h004) begin
      failures++;
      $display("FAIL reset actual=%h required=%h",
               {out, negative, zero, carry_out, overflow}, 12'h004);
    end
    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].r;
      a = vecs[i].va;
      b = vecs[i].vb;
      select = vecs[i].s;
      @(posedge clk);
      #2;
      checks++;
      if ({out, negative, zero, carry_out, overflow} !== {vecs[i].eo, vecs[i].nzcv}) begin
        failures++;
        $display("FAIL vec%0d actual=%h required=%h", i,
                 {out, negative, zero, carry_out, overflow}, {vecs[i].eo, vecs[i].nzcv});
      end
    end
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/arithmetic_logic_unit.md
ARITHMETIC_LOGIC_UNIT -- requirements
Module: arithmetic_logic_unit

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal range 2..64.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 a  input  WIDTH  operand A; shifted/rotated value for shift ops.
REQ-005 b  input  WIDTH  operand B; shift/rotate amount for shift ops.
REQ-006 select  input  4  operation code.
REQ-007 out  output  WIDTH  registered result.
REQ-008 negative  output  1  registered: out MSB.
REQ-009 zero  output  1  registered: out equals 0.
REQ-010 carry_out  output  1  registered carry/no-borrow flag.
REQ-011 overflow  output  1  registered signed-overflow flag.
REQ-012 Port order SHALL be clk, rst, a, b, select, out, negative, zero, carry_out, overflow.

Function
REQ-013 Result and flags SHALL be computed combinationally from a, b, select and registered on each rising clk edge; latency exactly 1 cycle, new operation every cycle, no handshake.
REQ-014 select 0: out = a OR b.
REQ-015 select 1: out = a XOR b.
REQ-016 select 2: out = a AND b.
REQ-017 select 3: out = a rotated left by (b mod WIDTH); WIDTH=8, a=0x4B, b=4 -> 0xB4.
REQ-018 select 4: out = a logical right shift by b; b >= WIDTH -> 0.
REQ-019 select 5: out = a logical left shift by b; b >= WIDTH -> 0.
REQ-020 select 8: out = (a + b) mod 2^WIDTH; carry_out = bit WIDTH of the unsigned sum; overflow = 1 iff a, b same sign and result sign differs.
REQ-021 select 9: out = (a - b) mod 2^WIDTH; carry_out = 1 iff a >= b unsigned (no borrow); overflow = 1 iff a, b differ in sign and result sign differs from a.
REQ-022 select 10: out = a arithmetic right shift by b (sign-filled); b >= WIDTH -> all bits = a MSB.
REQ-023 select 6, 7, 11-15: out = 0 (no tri-state drive).
REQ-024 For every op except 8 and 9, carry_out = 0 and overflow = 0.
REQ-025 For every op, negative = out[WIDTH-1] and zero = (out == 0), derived from the value being registered.
REQ-026 Operands SHALL be treated as unsigned for shifts/logic, two's complement for overflow/arithmetic shift.

Reset
REQ-027 While rst=1 at a rising edge: out=0, negative=0, zero=1, carry_out=0, overflow=0; inputs ignored.
REQ-028 First valid result appears on the edge after rst deasserts; reset asserted mid-stream discards the in-flight result.

Structure
REQ-029 Shared package alu_pkg SHALL hold the opcode enum (OP_OR=0, OP_XOR=1, OP_AND=2, OP_ROL=3, OP_SRL=4, OP_SLL=5, OP_ADD=8, OP_SUB=9, OP_SRA=10) and the 4-bit opcode typedef.
REQ-030 One sub-module alu_shifter (combinational, parameterised WIDTH) SHALL implement ROL/SRL/SLL/SRA; adder/subtractor and logic stay in the top.
REQ-031 Exactly one register stage (out plus four flags); no other state.

Verification
REQ-032 WIDTH=8, a=0x4B, b=0x04, select 0,1,2 -> one cycle later out = 0x4F, 0x4F, 0x00 (zero=1 for AND).
REQ-033 Same operands, select 3,4,5,10 -> out = 0xB4 (negative=1), 0x04, 0xB0, 0x04; carry_out=overflow=0.
REQ-034 Same operands, select 8 -> 0x4F, carry 0, ovf 0; select 9 -> 0x47 (71), carry 1, ovf 0.
REQ-035 a=0x7F, b=0x01, select 8 -> 0x80, negative=1, overflow=1, carry 0; a=0xFF, b=0x01, select 8 -> 0x00, zero=1, carry 1.
REQ-036 a=0x80, b=0x09, select 10 -> 0xFF; select 4 -> 0x00; select 9 with a=0x00, b=0x01 -> 0xFF, carry 0.
REQ-037 Assert rst during ops -> next edge out=0, zero=1, other flags 0; select 6/7/11 -> out=0 one cycle after.
